// File: rtl/clint.sv
// Core-local interruptor: MSIP, 64-bit mtime with prescaler, mtimecmp and a
// single-outstanding valid/ready register port with a registered response.
module clint #(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        wena,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [31:0] rdata,
    output logic        err,
    output logic        irq_timer,
    output logic        irq_software
);

    localparam logic [2:0] AddrMsip     = 3'd0;
    localparam logic [2:0] AddrCmpLo    = 3'd1;
    localparam logic [2:0] AddrCmpHi    = 3'd2;
    localparam logic [2:0] AddrTimeLo   = 3'd3;
    localparam logic [2:0] AddrTimeHi   = 3'd4;
    localparam logic [2:0] AddrPrescale = 3'd5;

    logic        msip_q;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic [31:0] shadow_q, shadow_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        irq_timer_q;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic [2:0]  word;
    logic        mapped;
    logic        tick;
    logic [31:0] read_val;
    logic        we_msip, we_cmp_lo, we_cmp_hi, we_time_lo, we_time_hi, we_prescale;
    logic        rd_time_lo;
    logic        unused_addr;

    assign unused_addr = ^addr[1:0];

    assign ready_out = !valid_q || ready_in;
    assign accept    = valid_in && ready_out;
    assign word      = addr[4:2];
    assign mapped    = (word <= AddrPrescale);

    assign we_msip     = accept && wena && (word == AddrMsip);
    assign we_cmp_lo   = accept && wena && (word == AddrCmpLo);
    assign we_cmp_hi   = accept && wena && (word == AddrCmpHi);
    assign we_time_lo  = accept && wena && (word == AddrTimeLo);
    assign we_time_hi  = accept && wena && (word == AddrTimeHi);
    assign we_prescale = accept && wena && (word == AddrPrescale);
    assign rd_time_lo  = accept && !wena && (word == AddrTimeLo);

    always_comb begin
        read_val = 32'd0;
        case (word)
            AddrMsip:     read_val = {31'd0, msip_q};
            AddrCmpLo:    read_val = mtimecmp_q[31:0];
            AddrCmpHi:    read_val = mtimecmp_q[63:32];
            AddrTimeLo:   read_val = mtime_q[31:0];
            AddrTimeHi:   read_val = shadow_q;
            AddrPrescale: read_val = {16'd0, prescale_q};
            default:      read_val = 32'd0;
        endcase
    end

    assign tick = (pcnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        pcnt_d     = tick ? 16'd0 : pcnt_q + 16'd1;
        if (we_prescale) begin
            prescale_d = wdata[15:0];
            pcnt_d     = 16'd0;
        end
    end

    // A write to either half suppresses that edge's tick entirely.
    always_comb begin
        mtime_d = mtime_q + {63'd0, tick};
        if (we_time_lo) begin
            mtime_d = {mtime_q[63:32], wdata};
        end else if (we_time_hi) begin
            mtime_d = {wdata, mtime_q[31:0]};
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (we_cmp_lo) begin
            mtimecmp_d[31:0] = wdata;
        end
        if (we_cmp_hi) begin
            mtimecmp_d[63:32] = wdata;
        end
    end

    assign shadow_d = rd_time_lo ? mtime_q[63:32] : shadow_q;

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            rdata_d = (wena || !mapped) ? 32'd0 : read_val;
            err_d   = !mapped;
        end else if (ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msip_q      <= 1'b0;
            mtimecmp_q  <= MTIMECMP_RST;
            mtime_q     <= 64'd0;
            shadow_q    <= 32'd0;
            prescale_q  <= PRESCALE_RST;
            pcnt_q      <= 16'd0;
            irq_timer_q <= 1'b0;
            valid_q     <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            if (we_msip) begin
                msip_q <= wdata[0];
            end
            mtimecmp_q  <= mtimecmp_d;
            mtime_q     <= mtime_d;
            shadow_q    <= shadow_d;
            prescale_q  <= prescale_d;
            pcnt_q      <= pcnt_d;
            irq_timer_q <= (mtime_q >= mtimecmp_q);
            valid_q     <= valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign valid_out    = valid_q;
    assign rdata        = rdata_q;
    assign err          = err_q;
    assign irq_timer    = irq_timer_q;
    assign irq_software = msip_q;

endmodule

// File: tb/tb_clint.sv
// Randomized and directed bench for clint against a cycle-level behavioural
// model of the register map, timer and response channel.
module tb_clint;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] rdata;
    logic        err;
    logic        irq_timer;
    logic        irq_software;

    clint #(
        .PRESCALE_RST(16'd0),
        .MTIMECMP_RST(64'd5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .wena        (wena),
        .addr        (addr),
        .wdata       (wdata),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .rdata       (rdata),
        .err         (err),
        .irq_timer   (irq_timer),
        .irq_software(irq_software)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow, m_rdata;
    logic [15:0] m_pre, m_pcnt;
    logic        m_msip, m_irq, m_vout, m_err;

    task automatic model_reset();
        m_mtime  = 64'd0;
        m_cmp    = 64'd5;
        m_shadow = 32'd0;
        m_rdata  = 32'd0;
        m_pre    = 16'd0;
        m_pcnt   = 16'd0;
        m_msip   = 1'b0;
        m_irq    = 1'b0;
        m_vout   = 1'b0;
        m_err    = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input int w);
        case (w)
            0: return {31'd0, m_msip};
            1: return m_cmp[31:0];
            2: return m_cmp[63:32];
            3: return m_mtime[31:0];
            4: return m_shadow;
            5: return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive at posedge+1, check ready_out, advance model, check outputs.
    task automatic step(input bit v, input bit w, input logic [4:0] a, input logic [31:0] d,
                        input bit ri);
        int          widx;
        bit          acc, tick;
        logic [63:0] n_mtime, n_cmp;
        logic [31:0] n_shadow, n_rdata;
        logic [15:0] n_pre, n_pcnt;
        logic        n_msip, n_vout, n_err;
        valid_in = v;
        wena     = w;
        addr     = a;
        wdata    = d;
        ready_in = ri;
        #1;
        check("ready_out", ready_out, !m_vout || ri);
        acc      = v && (!m_vout || ri);
        widx     = int'(a) / 4;
        tick     = (m_pcnt == m_pre);
        n_mtime  = m_mtime + (tick ? 64'd1 : 64'd0);
        n_pcnt   = tick ? 16'd0 : m_pcnt + 16'd1;
        n_cmp    = m_cmp;
        n_shadow = m_shadow;
        n_pre    = m_pre;
        n_msip   = m_msip;
        n_vout   = m_vout;
        n_rdata  = m_rdata;
        n_err    = m_err;
        if (acc) begin
            n_vout  = 1'b1;
            n_err   = (widx > 5);
            n_rdata = (w || widx > 5) ? 32'd0 : m_read(widx);
            if (!w && widx == 3) n_shadow = m_mtime[63:32];
            if (w) begin
                case (widx)
                    0: n_msip = d[0];
                    1: n_cmp[31:0] = d;
                    2: n_cmp[63:32] = d;
                    3: n_mtime = {m_mtime[63:32], d};
                    4: n_mtime = {d, m_mtime[31:0]};
                    5: begin
                        n_pre  = d[15:0];
                        n_pcnt = 16'd0;
                    end
                    default: ;
                endcase
            end
        end else if (ri) begin
            n_vout = 1'b0;
        end
        @(posedge clk);
        m_irq    = (m_mtime >= m_cmp);
        m_mtime  = n_mtime;
        m_pcnt   = n_pcnt;
        m_cmp    = n_cmp;
        m_shadow = n_shadow;
        m_pre    = n_pre;
        m_msip   = n_msip;
        m_vout   = n_vout;
        m_rdata  = n_rdata;
        m_err    = n_err;
        #1;
        check("valid_out", valid_out, m_vout);
        check("irq_timer", irq_timer, m_irq);
        check("irq_software", irq_software, m_msip);
        if (m_vout) begin
            check("rdata", rdata, m_rdata);
            check("err", err, m_err);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d, 1'b1);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b1, 1'b0, a, 32'd0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_out"}, valid_out, 1'b0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_irq_timer"}, irq_timer, 1'b0);
        check({tag, "_irq_sw"}, irq_software, 1'b0);
        check({tag, "_ready_out"}, ready_out, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        wena     = 1'b0;
        addr     = 5'd0;
        wdata    = 32'd0;
        ready_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // Timer reaches mtimecmp=5 at edge 5; irq_timer visible from edge 6.
        idle(5);
        check("irq_before_edge6", irq_timer, 1'b0);
        idle(1);
        check("irq_at_edge6", irq_timer, 1'b1);
        rd(5'h0C);

        // Prescale of 3, then a restart mid-period.
        wr(5'h14, 32'd3);
        for (int i = 0; i < 10; i++) rd(5'h0C);
        idle(2);
        wr(5'h14, 32'd3);
        for (int i = 0; i < 9; i++) rd(5'h0C);
        rd(5'h14);

        // Coherent 64-bit read across a carry.
        wr(5'h14, 32'd0);
        wr(5'h10, 32'h1234_5678);
        wr(5'h0C, 32'hFFFF_FFFF);
        rd(5'h0C);
        check("carry_lo", rdata, 32'hFFFF_FFFF);
        rd(5'h10);
        check("shadow_hi", rdata, 32'h1234_5678);

        // Low-half write beats a coincident tick; full wrap.
        wr(5'h0C, 32'h10);
        rd(5'h0C);
        check("wr_no_inc", rdata, 32'h10);
        wr(5'h10, 32'hFFFF_FFFF);
        wr(5'h0C, 32'hFFFF_FFFF);
        rd(5'h0C);
        rd(5'h0C);
        check("wrap_lo", rdata, 32'd0);
        rd(5'h10);
        check("wrap_hi", rdata, 32'd0);

        // Backpressure on a pending read, then unmapped accesses.
        idle(1);
        step(1'b1, 1'b0, 5'h14, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'h0C, 32'd0, 1'b0);
        idle(1);
        rd(5'h18);
        check("unmapped_err", err, 1'b1);
        check("unmapped_rdata", rdata, 32'd0);
        wr(5'h1C, 32'hDEAD_BEEF);
        rd(5'h00);

        // Software and timer interrupt control.
        wr(5'h00, 32'd1);
        check("msip_irq", irq_software, 1'b1);
        wr(5'h08, 32'd0);
        wr(5'h04, 32'd0);
        idle(2);
        check("irq_cmp0", irq_timer, 1'b1);
        wr(5'h08, 32'hFFFF_FFFF);
        idle(1);
        check("irq_cleared", irq_timer, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit          v, w, ri;
            logic [4:0]  a;
            logic [31:0] d;
            v  = ($urandom % 4) != 0;
            w  = ($urandom % 2) != 0;
            ri = ($urandom % 4) != 0;
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            if (a[4:2] == 3'd5) d = $urandom % 6;
            if (a[4:2] == 3'd4 && ($urandom % 2) != 0) d = 32'hFFFF_FFFF;
            step(v, w, a, d, ri);
        end

        // Reset with a response pending drops it.
        idle(1);
        step(1'b1, 1'b0, 5'h0C, 32'd0, 1'b0);
        reset = 1'b1;
        valid_in = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        reset = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter PRESCALE_RST, default 16'd0, reset value of the PRESCALE register.
REQ-002 Parameter MTIMECMP_RST, default 64'hFFFFFFFF_FFFFFFFF, reset value of mtimecmp.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valid_in  input  1  bus request valid.
REQ-006 ready_out  output  1  block can accept a request this cycle.
REQ-007 wena  input  1  request is a write (1) or a read (0).
REQ-008 addr  input  5  byte address, word-aligned; addr[1:0] ignored.
REQ-009 wdata  input  32  write data.
REQ-010 valid_out  output  1  response valid.
REQ-011 ready_in  input  1  downstream accepts the response.
REQ-012 rdata  output  32  read data, 0 for writes and errors.
REQ-013 err  output  1  response flags an unmapped address.
REQ-014 irq_timer  output  1  machine timer interrupt, to csr_file irq_timer.
REQ-015 irq_software  output  1  machine software interrupt, to csr_file irq_software.

Function
REQ-016 Register map: 0x00 MSIP (bit0 RW, rest read 0); 0x04 MTIMECMP[31:0]; 0x08 MTIMECMP[63:32]; 0x0C MTIME[31:0]; 0x10 MTIME[63:32]; 0x14 PRESCALE (bits 15:0 RW, rest read 0); all other addresses unmapped.
REQ-017 Handshake: ready_out = !valid_out || ready_in; a request is accepted when valid_in && ready_out.
REQ-018 An accepted request produces its response in the next cycle: valid_out=1 with rdata/err registered.
REQ-019 valid_out, rdata and err hold stable until valid_out && ready_in; without a new accept, valid_out then clears.
REQ-020 An accept in the same cycle as a response handshake loads the new response without a bubble, giving one request per cycle throughput.
REQ-021 A write takes effect at the accept edge; write responses return rdata=0.
REQ-022 An unmapped access returns err=1 and rdata=0; an unmapped write changes no state.
REQ-023 Prescaler: a 16-bit counter pcnt; when pcnt==PRESCALE, pcnt<=0 and a tick increments mtime by 1; otherwise pcnt increments.
REQ-024 With PRESCALE=0, mtime increments every cycle. With PRESCALE=N, it increments every N+1 cycles.
REQ-025 A write to PRESCALE sets pcnt<=0 at the same edge.
REQ-026 mtime is 64-bit unsigned and wraps from 64'hFFFFFFFF_FFFFFFFF to 0 with no flag.
REQ-027 A write to either MTIME half replaces that half. The other half keeps its current value, with no increment on that edge; the write wins over a coincident tick.
REQ-028 A read of MTIME[31:0] returns mtime[31:0] and latches mtime[63:32] into a shadow register at the accept edge.
REQ-029 A read of MTIME[63:32] returns the shadow register, not live mtime; this gives software a coherent low-then-high 64-bit read.
REQ-030 irq_timer is registered: at each edge it loads (mtime >= mtimecmp), an unsigned 64-bit compare of the pre-edge values, so it lags the condition by one cycle.
REQ-031 irq_timer is level, not latched: it deasserts one cycle after a write raises mtimecmp above mtime.
REQ-032 irq_software equals the MSIP bit0 register directly.

Reset
REQ-033 While reset=1, the block holds these values: valid_out=0, rdata=0, err=0, irq_timer=0, irq_software=0, mtime=0, shadow=0, pcnt=0, MSIP=0, PRESCALE=PRESCALE_RST, mtimecmp=MTIMECMP_RST.
REQ-034 Reset is effective mid-transaction; a pending response is dropped and not re-issued.
REQ-035 ready_out=1 during and immediately after reset.

Verification
REQ-036 PRESCALE=0, mtimecmp=5, from reset -> mtime reaches 5 at edge 5; irq_timer=1 from edge 6.
REQ-037 Write PRESCALE=3 -> mtime increments exactly every 4 cycles; a PRESCALE rewrite mid-count restarts the 4-cycle period.
REQ-038 mtime=32'hFFFFFFFF (low half), read low then read high after a carry -> the high read returns the pre-carry high half via the shadow register.
REQ-039 Write MTIME low=0x10 on a tick edge -> mtime low=0x10 with no +1. Set mtime=all-ones -> mtime wraps to 0 on the next tick.
REQ-040 Hold ready_in=0 for 3 cycles with a read pending -> valid_out and rdata are stable and ready_out=0. Read addr 0x18 -> err=1, rdata=0.
REQ-041 Write MSIP=1 -> irq_software=1 at the next cycle. Write MTIMECMP high=0xFFFFFFFF while irq_timer=1 -> irq_timer=0 after one cycle.
